// File: rtl/note_display_pkg.sv
// Shared constants and FSM encoding for the note display path
// (note-name lookup, text renderer, frame-buffer writer).
package note_display_pkg;

  localparam int unsigned NUM_CHARS   = 5;
  localparam int unsigned CHAR_ADDR_W = 9;
  localparam int unsigned GLYPH_W     = 8;
  localparam int unsigned GLYPH_H     = 8;
  localparam int unsigned NOTE_ADDR_W = NUM_CHARS * CHAR_ADDR_W;

  localparam int unsigned CHAR_IDX_W  = 3;
  localparam int unsigned ROW_W       = 3;
  localparam int unsigned BIT_W       = 3;
  localparam int unsigned PIX_X_W     = CHAR_IDX_W + BIT_W;

  localparam logic [CHAR_ADDR_W-1:0] CHAR_BLANK_ADDR = 9'd256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } render_state_e;

  // Base address of character idx; char0 sits in the most significant field.
  function automatic logic [CHAR_ADDR_W-1:0] char_field(
    input logic [NOTE_ADDR_W-1:0] word,
    input logic [CHAR_IDX_W-1:0]  idx
  );
    logic [CHAR_ADDR_W-1:0] f;
    f = '0;
    for (int unsigned i = 0; i < NUM_CHARS; i++) begin
      if (idx == CHAR_IDX_W'(i)) f = word[(NUM_CHARS-1-i)*CHAR_ADDR_W +: CHAR_ADDR_W];
    end
    return f;
  endfunction

endpackage

// File: rtl/note_text_renderer_glyph_shifter.sv
// Glyph row shift register: loads one font-ROM row, shifts MSB-first on
// each accepted pixel and tracks the bit position within the row.
module glyph_shifter
  import note_display_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [GLYPH_W-1:0] data_i,
  input  logic               shift_i,
  output logic               msb_o,
  output logic [BIT_W-1:0]   bit_o,
  output logic               last_bit_o
);

  logic [GLYPH_W-1:0] data_q;
  logic [BIT_W-1:0]   bit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      bit_q  <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      bit_q  <= '0;
    end else if (shift_i) begin
      data_q <= {data_q[GLYPH_W-2:0], 1'b0};
      bit_q  <= bit_q + 1'b1;
    end
  end

  assign msb_o      = data_q[GLYPH_W-1];
  assign bit_o      = bit_q;
  assign last_bit_o = (bit_q == BIT_W'(GLYPH_W-1));

endmodule

// File: rtl/note_text_renderer.sv
// Renders a 5-character note label into a 40x8 pixel stream by walking
// glyph rows through a 1-cycle-latency font ROM.
module note_text_renderer
  import note_display_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NOTE_ADDR_W-1:0] note_addr,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [CHAR_ADDR_W-1:0] rom_addr,
  input  logic [GLYPH_W-1:0]     rom_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_on,
  output logic [PIX_X_W-1:0]     pix_x,
  output logic [ROW_W-1:0]       pix_y
);

  render_state_e          state_q;
  logic [NOTE_ADDR_W-1:0] addr_q;
  logic [CHAR_IDX_W-1:0]  char_q;
  logic [ROW_W-1:0]       row_q;
  logic [CHAR_ADDR_W-1:0] rom_addr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pix_valid_q;

  logic [CHAR_IDX_W-1:0]  char_d;
  logic [ROW_W-1:0]       row_d;
  logic [CHAR_ADDR_W-1:0] rom_addr_d;
  logic                   last_char;
  logic                   last_row;
  logic                   handshake;
  logic                   shift_msb;
  logic [BIT_W-1:0]       bit_idx;
  logic                   last_bit;

  assign handshake = pix_valid_q & pix_ready;

  always_comb begin
    last_char  = (char_q == CHAR_IDX_W'(NUM_CHARS-1));
    last_row   = (row_q == ROW_W'(GLYPH_H-1));
    char_d     = last_char ? '0 : char_q + 1'b1;
    row_d      = last_char ? row_q + 1'b1 : row_q;
    rom_addr_d = char_field(addr_q, char_d) + CHAR_ADDR_W'(row_d);
  end

  // rom_addr is registered on entry to FETCH so the ROM sees it for the whole
  // FETCH cycle and rom_data is ready to capture at the end of WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      char_q      <= '0;
      row_q       <= '0;
      rom_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q     <= note_addr;
            char_q     <= '0;
            row_q      <= '0;
            rom_addr_q <= note_addr[NOTE_ADDR_W-1 -: CHAR_ADDR_W];
            busy_q     <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          pix_valid_q <= 1'b1;
          state_q     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (handshake && last_bit) begin
            pix_valid_q <= 1'b0;
            if (last_char && last_row) begin
              char_q  <= '0;
              row_q   <= '0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              char_q     <= char_d;
              row_q      <= row_d;
              rom_addr_q <= rom_addr_d;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  glyph_shifter u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (state_q == ST_WAIT),
    .data_i     (rom_data),
    .shift_i    (handshake),
    .msb_o      (shift_msb),
    .bit_o      (bit_idx),
    .last_bit_o (last_bit)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_addr  = rom_addr_q;
  assign pix_valid = pix_valid_q;
  assign pix_on    = pix_valid_q & shift_msb;
  assign pix_x     = {char_q, bit_idx};
  assign pix_y     = row_q;

endmodule

// File: tb/tb_note_text_renderer.sv
// Directed bench for note_text_renderer with a behavioural font ROM.
module tb_note_text_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [44:0] note_addr;
  logic        start;
  logic        busy, done;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        pix_valid, pix_ready, pix_on;
  logic [5:0]  pix_x;
  logic [2:0]  pix_y;

  int errors = 0;
  int checks = 0;
  int rom_mode = 0;

  typedef struct {
    logic [44:0] addr;
    int          mode;
    bit          stall;
    bit          poke;
    bit          abort;
    int          exp_first;
    int          exp_done;
    int          exp_pixels;
  } vec_t;

  vec_t vecs[6];

  note_text_renderer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .note_addr (note_addr),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_on    (pix_on),
    .pix_x     (pix_x),
    .pix_y     (pix_y)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input int mode, input logic [8:0] a);
    logic [7:0] v;
    if (mode == 1) v = 8'hA5;
    else           v = a[7:0] ^ {a[8], a[3:0], a[8:6]};
    return v;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_mode, rom_addr);

  function automatic logic [8:0] fld(input logic [44:0] a, input int c);
    logic [44:0] t;
    t = a >> (9 * (4 - c));
    return t[8:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_pix_on"}, int'(pix_on), 0);
    chk({tag, "_pix_x"}, int'(pix_x), 0);
    chk({tag, "_pix_y"}, int'(pix_y), 0);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
  endtask

  task automatic run_render(input vec_t v);
    int k, stalls, first_v, done_c, last_hs, r, c, b;
    bit aborted;
    logic [8:0] base;
    logic [7:0] d;
    k = 0; stalls = 0; first_v = -1; done_c = -1; last_hs = -1; aborted = 0;
    rom_mode = v.mode;
    @(negedge clk);
    note_addr = v.addr;
    start     = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 600 && done_c < 0; n++) begin
      @(negedge clk);
      if (v.poke && n == 50) begin
        start     = 1'b1;
        note_addr = ~v.addr;
      end
      if (v.poke && n == 51) start = 1'b0;
      if (v.abort && k == 200) begin
        reset_n = 1'b0;
        #1 chk_all_zero("abort_async");
        aborted = 1;
        break;
      end
      pix_ready = !(v.stall && k == 179 && pix_valid && stalls < 5);
      if (!pix_ready) stalls++;
      chk("busy_during", int'(busy), 1);
      if (done) done_c = n;
      if (pix_valid) begin
        if (first_v < 0) first_v = n;
        r    = k / 40;
        c    = (k % 40) / 8;
        b    = k % 8;
        base = fld(v.addr, c) + 9'(r);
        d    = rom_fn(v.mode, base);
        chk("pix_on", int'(pix_on), int'(d[7-b]));
        chk("pix_x", int'(pix_x), k % 40);
        chk("pix_y", int'(pix_y), r);
        if (b == 0) chk("rom_addr", int'(rom_addr), int'(base));
        if (pix_ready) begin
          k++;
          last_hs = n;
        end
      end
    end
    pix_ready = 1'b1;
    if (aborted) begin
      chk("abort_pixels", k, v.exp_pixels);
      @(posedge clk);
      #1 chk_all_zero("abort_held");
      @(negedge clk);
      reset_n = 1'b1;
    end else begin
      if (done_c < 0) begin
        errors++;
        checks++;
        $display("FAIL timeout: done not seen, pixels=%0d", k);
      end
      chk("first_valid_cycle", first_v, v.exp_first);
      chk("done_cycle", done_c, v.exp_done);
      chk("last_handshake_cycle", last_hs, v.exp_done - 1);
      chk("pixel_count", k, v.exp_pixels);
      chk("stall_cycles", stalls, v.stall ? 5 : 0);
      @(negedge clk);
      chk("idle_done", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_pix_valid", int'(pix_valid), 0);
    end
  endtask

  initial begin
    vecs[0] = '{addr: {9'd392, 9'd8, 9'd256, 9'd256, 9'd256}, mode: 0, stall: 0, poke: 0,
                abort: 0, exp_first: 3, exp_done: 401, exp_pixels: 320};
    vecs[1] = '{addr: {9'd392, 9'd8, 9'd256, 9'd256, 9'd256}, mode: 1, stall: 0, poke: 0,
                abort: 0, exp_first: 3, exp_done: 401, exp_pixels: 320};
    vecs[2] = '{addr: {9'd264, 9'd272, 9'd280, 9'd288, 9'd509}, mode: 0, stall: 1, poke: 0,
                abort: 0, exp_first: 3, exp_done: 406, exp_pixels: 320};
    vecs[3] = '{addr: {9'd392, 9'd8, 9'd256, 9'd256, 9'd256}, mode: 0, stall: 0, poke: 1,
                abort: 0, exp_first: 3, exp_done: 401, exp_pixels: 320};
    vecs[4] = '{addr: {9'd16, 9'd24, 9'd32, 9'd40, 9'd48}, mode: 0, stall: 0, poke: 0,
                abort: 1, exp_first: 3, exp_done: 0, exp_pixels: 200};
    vecs[5] = '{addr: {9'd8, 9'd16, 9'd24, 9'd32, 9'd40}, mode: 0, stall: 0, poke: 0,
                abort: 0, exp_first: 3, exp_done: 401, exp_pixels: 320};

    reset_n   = 1'b0;
    start     = 1'b0;
    note_addr = '0;
    pix_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      note_addr = {13'($urandom), $urandom};
      start     = 1'($urandom_range(0, 1));
      pix_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_all_zero("reset");
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    reset_n   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_all_zero("idle_no_start");
    end

    for (int i = 0; i < 6; i++) run_render(vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
